boreal_frame_asm: RTL and testbench

//  Downstream of the 8-channel round-robin scheduler. Collects channel-tagged ADC samples
//  (in_ch = scheduler index, in_valid = the scheduler tick) into a full 8-lane frame.

---
 rtl/boreal_frame_asm.sv | 131 +++++++++++++
 tb/tb_boreal_frame_asm.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_frame_asm.sv
// boreal_frame_asm
// Builds 8-lane frames from channel-tagged ADC samples that arrive in
// round-robin order. Each complete frame goes out on a valid/ready register.
// Channel-order violations are counted and the assembler resynchronises.
// Frames that complete while the output is still occupied are dropped and counted.

module boreal_frame_asm #(
  parameter int DW    = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        in_ch,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*DW-1:0]   out_data,
  output logic [7:0]        out_seq,
  output logic              in_sync,
  output logic [CNT_W-1:0]  seq_err_cnt,
  output logic [CNT_W-1:0]  ovf_cnt
);

  typedef enum logic {
    SYNC = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q;
  logic [2:0]         exp_q;
  logic [DW-1:0]      lanes_q [8];
  logic               out_valid_q;
  logic [8*DW-1:0]    out_data_q;
  logic [7:0]         out_seq_q;
  logic [CNT_W-1:0]   seq_err_q;
  logic [CNT_W-1:0]   ovf_q;

  logic               chMatch_d;
  logic               complete_d;
  logic               slotFree_d;
  logic [8*DW-1:0]    frame_d;

  // Decode this cycle's sample and stage the full frame (lane 7 comes straight from the input)
  always_comb begin
    chMatch_d  = (in_ch == exp_q);
    complete_d = in_valid && (state_q == FILL) && chMatch_d && (exp_q == 3'd7);
    slotFree_d = !out_valid_q || out_ready;
    frame_d    = '0;
    for (int k = 0; k < 7; k++) begin
      frame_d[k*DW +: DW] = lanes_q[k];
    end
    frame_d[7*DW +: DW] = in_data;
  end

  // Assembly FSM, error/overflow counters and the output frame register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      exp_q       <= 3'd0;
      for (int k = 0; k < 8; k++) begin
        lanes_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_seq_q   <= 8'd0;
      seq_err_q   <= '0;
      ovf_q       <= '0;
    end else begin
      case (state_q)
        SYNC: begin
          if (in_valid && (in_ch == 3'd0)) begin
            lanes_q[0] <= in_data;
            exp_q      <= 3'd1;
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (in_valid) begin
            if (chMatch_d) begin
              lanes_q[exp_q] <= in_data;
              if (exp_q == 3'd7) begin
                exp_q <= 3'd0;
              end else begin
                exp_q <= exp_q + 3'd1;
              end
            end else begin
              if (seq_err_q != CNT_MAX) begin
                seq_err_q <= seq_err_q + CNT_ONE;
              end
              if (in_ch == 3'd0) begin
                lanes_q[0] <= in_data;
                exp_q      <= 3'd1;
              end else begin
                exp_q   <= 3'd0;
                state_q <= SYNC;
              end
            end
          end
        end
        default: begin
          state_q <= SYNC;
          exp_q   <= 3'd0;
        end
      endcase

      if (complete_d) begin
        if (slotFree_d) begin
          out_data_q  <= frame_d;
          out_valid_q <= 1'b1;
          out_seq_q   <= out_seq_q + 8'd1;
        end else if (ovf_q != CNT_MAX) begin
          ovf_q <= ovf_q + CNT_ONE;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_seq     = out_seq_q;
  assign in_sync     = (state_q == FILL);
  assign seq_err_cnt = seq_err_q;
  assign ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_boreal_frame_asm.sv
// Self-checking bench for boreal_frame_asm: a hand-derived vector table,
// directed multi-cycle sequences and random traffic against a queue-based model.

module tb_boreal_frame_asm;

  localparam int DW    = 16;
  localparam int CNT_W = 8;

  logic              clk;
  logic              rst;
  logic              inValid;
  logic [2:0]        inCh;
  logic [DW-1:0]     inData;
  logic              outValid;
  logic              outReady;
  logic [8*DW-1:0]   outData;
  logic [7:0]        outSeq;
  logic              inSync;
  logic [CNT_W-1:0]  seqErrCnt;
  logic [CNT_W-1:0]  ovfCnt;

  int total = 0;
  int bad   = 0;

  boreal_frame_asm #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (inValid),
    .in_ch       (inCh),
    .in_data     (inData),
    .out_valid   (outValid),
    .out_ready   (outReady),
    .out_data    (outData),
    .out_seq     (outSeq),
    .in_sync     (inSync),
    .seq_err_cnt (seqErrCnt),
    .ovf_cnt     (ovfCnt)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a queue holds the samples of the frame in progress;
  // a frame is valid while the next channel equals the number of samples held.
  bit               mSynced;
  logic [DW-1:0]    mPart[$];
  bit               mOutValid;
  logic [8*DW-1:0]  mOutData;
  int               mOutSeq;
  int               mErr;
  int               mOvf;

  function automatic void modelReset();
    mSynced   = 0;
    mPart.delete();
    mOutValid = 0;
    mOutData  = '0;
    mOutSeq   = 0;
    mErr      = 0;
    mOvf      = 0;
  endfunction

  function automatic void modelStep(bit v, int ch, logic [DW-1:0] d, bit rdy);
    bit done;
    logic [8*DW-1:0] frame;
    done  = 0;
    frame = '0;
    if (v) begin
      if (!mSynced) begin
        if (ch == 0) begin
          mPart.delete();
          mPart.push_back(d);
          mSynced = 1;
        end
      end else if (ch == mPart.size()) begin
        mPart.push_back(d);
        if (mPart.size() == 8) begin
          for (int k = 0; k < 8; k++) frame[k*DW +: DW] = mPart[k];
          mPart.delete();
          done = 1;
        end
      end else begin
        if (mErr < 255) mErr++;
        mPart.delete();
        if (ch == 0) mPart.push_back(d);
        else mSynced = 0;
      end
    end
    if (done) begin
      if (!mOutValid || rdy) begin
        mOutValid = 1;
        mOutData  = frame;
        mOutSeq   = (mOutSeq + 1) % 256;
      end else if (mOvf < 255) begin
        mOvf++;
      end
    end else if (mOutValid && rdy) begin
      mOutValid = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [8*DW-1:0] act, input logic [8*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every DUT output with the model
  task automatic checkOutput(input string tag);
    chk({tag, ".valid"}, 128'(outValid), 128'(mOutValid));
    chk({tag, ".seq"},   128'(outSeq),   128'(mOutSeq));
    chk({tag, ".sync"},  128'(inSync),   128'(mSynced));
    chk({tag, ".err"},   128'(seqErrCnt), 128'(mErr));
    chk({tag, ".ovf"},   128'(ovfCnt),   128'(mOvf));
    if (mOutValid) chk({tag, ".data"}, outData, mOutData);
  endtask

  // Drive one cycle of inputs at the falling edge; outputs settle by the next falling edge
  task automatic applyStimulus(input bit v, input int ch, input logic [DW-1:0] d, input bit rdy);
    inValid  = v;
    inCh     = 3'(ch);
    inData   = d;
    outReady = rdy;
    modelStep(v, ch, d, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset(input string tag);
    rst      = 1'b1;
    inValid  = 1'b1;
    inCh     = 3'd0;
    inData   = 16'hDEAD;
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    inValid = 1'b0;
    modelReset();
    checkOutput(tag);
    chk({tag, ".data0"}, outData, '0);
  endtask

  task automatic sendFrame(input int base, input bit rdy);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1, c, 16'(base + c), rdy);
      checkOutput("frame");
    end
  endtask

  typedef struct {
    bit               v;
    int               ch;
    logic [DW-1:0]    d;
    bit               rdy;
    bit               eValid;
    int               eSeq;
    bit               eSync;
    int               eErr;
    int               eOvf;
    bit               chkData;
    logic [8*DW-1:0]  eData;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(bit v, int ch, bit eValid, int eSeq, bit eSync, int eErr,
                                 bit chkData);
    vec_t x;
    x.v       = v;
    x.ch      = ch;
    x.d       = 16'(16'h0100 + ch);
    x.rdy     = 1;
    x.eValid  = eValid;
    x.eSeq    = eSeq;
    x.eSync   = eSync;
    x.eErr    = eErr;
    x.eOvf    = 0;
    x.chkData = chkData;
    x.eData   = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
    vecs.push_back(x);
  endfunction

  initial begin
    rst      = 1'b0;
    inValid  = 1'b0;
    inCh     = 3'd0;
    inData   = '0;
    outReady = 1'b0;
    @(negedge clk);

    // Hand-derived table: basic frame, immediate restart, error to SYNC and relock
    for (int c = 0; c < 7; c++) addVec(1, c, 0, 0, 1, 0, 0);
    addVec(1, 7, 1, 1, 1, 0, 1);
    addVec(0, 0, 0, 1, 1, 0, 0);
    for (int c = 0; c < 3; c++) addVec(1, c, 0, 1, 1, 0, 0);
    addVec(1, 0, 0, 1, 1, 1, 0);
    for (int c = 1; c < 7; c++) addVec(1, c, 0, 1, 1, 1, 0);
    addVec(1, 7, 1, 2, 1, 1, 1);
    addVec(0, 0, 0, 2, 1, 1, 0);
    addVec(1, 3, 0, 2, 0, 2, 0);
    addVec(1, 5, 0, 2, 0, 2, 0);
    addVec(1, 0, 0, 2, 1, 2, 0);

    doReset("reset1");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v, vecs[i].ch, vecs[i].d, vecs[i].rdy);
      chk($sformatf("vec%0d.valid", i), 128'(outValid),  128'(vecs[i].eValid));
      chk($sformatf("vec%0d.seq", i),   128'(outSeq),    128'(vecs[i].eSeq));
      chk($sformatf("vec%0d.sync", i),  128'(inSync),    128'(vecs[i].eSync));
      chk($sformatf("vec%0d.err", i),   128'(seqErrCnt), 128'(vecs[i].eErr));
      chk($sformatf("vec%0d.ovf", i),   128'(ovfCnt),    128'(vecs[i].eOvf));
      if (vecs[i].chkData) chk($sformatf("vec%0d.data", i), outData, vecs[i].eData);
    end

    // Output stalled: second frame dropped, first held, then drained
    doReset("reset2");
    sendFrame(16'h0200, 0);
    sendFrame(16'h0300, 0);
    chk("stall.ovf", 128'(ovfCnt), 128'(1));
    chk("stall.heldData", outData, 128'h0207_0206_0205_0204_0203_0202_0201_0200);
    applyStimulus(0, 0, 0, 1);
    checkOutput("drain");
    chk("drain.valid", 128'(outValid), 128'(0));

    // Error into SYNC, ignored channels, relock on ch0
    doReset("reset3");
    applyStimulus(1, 0, 16'h10, 1); checkOutput("err3");
    applyStimulus(1, 1, 16'h11, 1); checkOutput("err3");
    applyStimulus(1, 2, 16'h12, 1); checkOutput("err3");
    applyStimulus(1, 5, 16'h15, 1); checkOutput("err3");
    applyStimulus(1, 6, 16'h16, 1); checkOutput("err3");
    applyStimulus(1, 7, 16'h17, 1); checkOutput("err3");
    chk("err3.syncLost", 128'(inSync), 128'(0));
    sendFrame(16'h0400, 1);
    chk("err3.seq", 128'(outSeq), 128'(1));
    chk("err3.cnt", 128'(seqErrCnt), 128'(1));

    // Back-to-back: consumer accepts in the same cycle the next frame completes
    doReset("reset5");
    sendFrame(16'h0500, 0);
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1, c, 16'(16'h0600 + c), 0);
      checkOutput("b2b");
    end
    applyStimulus(1, 7, 16'h0607, 1);
    checkOutput("b2b7");
    chk("b2b.valid", 128'(outValid), 128'(1));
    chk("b2b.seq", 128'(outSeq), 128'(2));

    // Counter saturation: repeated ch0 is an error on every sample after the first
    doReset("reset6");
    for (int i = 0; i < 301; i++) applyStimulus(1, 0, 16'(i), 0);
    checkOutput("sat");
    chk("sat.err", 128'(seqErrCnt), 128'(255));

    // Mid-frame reset clears everything
    sendFrame(16'h0700, 1);
    applyStimulus(1, 0, 16'h0800, 1);
    applyStimulus(1, 1, 16'h0801, 1);
    doReset("midReset");
    chk("midReset.sync", 128'(inSync), 128'(0));
    chk("midReset.err", 128'(seqErrCnt), 128'(0));

    // Random traffic: mostly in-order channels with occasional glitches
    begin
      int cursor;
      cursor = 0;
      for (int i = 0; i < 3000; i++) begin
        bit v;
        bit r;
        int ch;
        v  = ($urandom_range(0, 3) != 0);
        r  = ($urandom_range(0, 1) == 1);
        ch = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : cursor;
        if (v) cursor = (ch + 1) % 8;
        applyStimulus(v, ch, 16'($urandom), r);
        checkOutput("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
